bsg_link_downstream_rx: RTL and testbench

Single-clock receive end of the off-chip source-synchronous token link. Accepts the two 8-bit I/O channels driven by the upstream transmitter, reassembles four 16-bit beats into one 64-bit core word, and buffers words in an internal FIFO. Words are presented to the core with a valid/yumi handshake. Credits go back to the upstream credit counters by toggling `io_token_o` once per batch of dequeued words.

---
 rtl/bsg_link_downstream_rx.sv | 133 +++++++++++++
 tb/tb_bsg_link_downstream_rx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bsg_link_downstream_rx.sv
// Receive end of the source-synchronous token link: assembles 16-bit beats into
// core words, buffers them in a FIFO and returns credits in batches via a toggling token.
module bsg_link_downstream_rx #(
    parameter int WIDTH_P         = 64,
    parameter int CHANNEL_WIDTH_P = 8,
    parameter int NUM_CHANNELS_P  = 2,
    parameter int FIFO_ELS_P      = 16,
    parameter int TOKEN_BATCH_P   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       io_valid_i,
    input  logic [CHANNEL_WIDTH_P-1:0] io_data_ch0_i,
    input  logic [CHANNEL_WIDTH_P-1:0] io_data_ch1_i,
    output logic                       io_token_o,
    output logic                       core_valid_o,
    output logic [WIDTH_P-1:0]         core_data_o,
    input  logic                       core_yumi_i,
    output logic                       overflow_o,
    output logic [6:0]                 recv_cnt_o,
    output logic [6:0]                 deq_cnt_o
);

    localparam int BEAT_W  = CHANNEL_WIDTH_P * NUM_CHANNELS_P;
    localparam int BEATS   = WIDTH_P / BEAT_W;
    localparam int BCNT_W  = $clog2(BEATS);
    localparam int ADDR_W  = $clog2(FIFO_ELS_P);
    localparam int PTR_W   = ADDR_W + 1;
    localparam int BATCH_W = $clog2(TOKEN_BATCH_P);
    localparam int PART_W  = WIDTH_P - BEAT_W;

    logic [BCNT_W-1:0]  r_beat;
    logic [PART_W-1:0]  r_partial;
    logic [WIDTH_P-1:0] r_mem [FIFO_ELS_P];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [BATCH_W-1:0] r_batch;
    logic               r_token;
    logic               r_overflow;
    logic [6:0]         r_recv_cnt;
    logic [6:0]         r_deq_cnt;

    logic               w_last_beat;
    logic               w_word_done;
    logic [WIDTH_P-1:0] w_word;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;

    assign w_last_beat = (r_beat == BCNT_W'(BEATS - 1));
    assign w_word_done = io_valid_i && w_last_beat;
    // The final beat bypasses the partial register and goes straight into the FIFO.
    assign w_word      = {io_data_ch1_i, io_data_ch0_i, r_partial};
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                         (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign w_pop       = core_yumi_i && !w_empty;
    // When full, a same-cycle pop frees the slot the new word lands in.
    assign w_push      = w_word_done && (!w_full || core_yumi_i);
    assign w_drop      = w_word_done && !w_push;

    assign core_valid_o = !w_empty;
    assign core_data_o  = r_mem[r_rd_ptr[ADDR_W-1:0]];
    assign io_token_o   = r_token;
    assign overflow_o   = r_overflow;
    assign recv_cnt_o   = r_recv_cnt;
    assign deq_cnt_o    = r_deq_cnt;

    // Beat counter and partial-word assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat    <= '0;
            r_partial <= '0;
        end else if (io_valid_i) begin
            r_beat <= r_beat + BCNT_W'(1);
            for (int k = 0; k < BEATS - 1; k++) begin
                if (r_beat == BCNT_W'(k)) begin
                    r_partial[k*BEAT_W +: BEAT_W] <= {io_data_ch1_i, io_data_ch0_i};
                end
            end
        end
    end

    // FIFO storage; cleared on reset so the head reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_ELS_P; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= w_word;
        end
    end

    // FIFO pointers, status counters and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_recv_cnt <= '0;
            r_deq_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
                r_recv_cnt <= r_recv_cnt + 7'd1;
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
                r_deq_cnt <= r_deq_cnt + 7'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Credit return: one token edge per full batch of pops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_batch <= '0;
            r_token <= 1'b0;
        end else if (w_pop) begin
            r_batch <= r_batch + BATCH_W'(1);
            if (r_batch == BATCH_W'(TOKEN_BATCH_P - 1)) begin
                r_token <= ~r_token;
            end
        end
    end

endmodule

// File: tb/tb_bsg_link_downstream_rx.sv
// Scoreboard bench for bsg_link_downstream_rx: directed words, decoupled pop monitor.
module tb_bsg_link_downstream_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        io_valid_i;
    logic [7:0]  io_data_ch0_i;
    logic [7:0]  io_data_ch1_i;
    logic        io_token_o;
    logic        core_valid_o;
    logic [63:0] core_data_o;
    logic        core_yumi_i;
    logic        overflow_o;
    logic [6:0]  recv_cnt_o;
    logic [6:0]  deq_cnt_o;

    logic [63:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    bsg_link_downstream_rx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .io_valid_i   (io_valid_i),
        .io_data_ch0_i(io_data_ch0_i),
        .io_data_ch1_i(io_data_ch1_i),
        .io_token_o   (io_token_o),
        .core_valid_o (core_valid_o),
        .core_data_o  (core_data_o),
        .core_yumi_i  (core_yumi_i),
        .overflow_o   (overflow_o),
        .recv_cnt_o   (recv_cnt_o),
        .deq_cnt_o    (deq_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && core_valid_o && core_yumi_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected actual=%h expected=none", core_data_o);
            end else begin
                chk("pop_data", core_data_o, exp_q.pop_front());
            end
        end
    end

    function automatic logic [63:0] wv(input int i);
        return {16'hF00D, 16'(i), 16'hBEEF, 16'(i * 3)};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input logic [7:0] c1, input logic [7:0] c0, input logic yumi);
        io_valid_i    = 1'b1;
        io_data_ch1_i = c1;
        io_data_ch0_i = c0;
        core_yumi_i   = yumi;
        @(posedge clk);
        #1;
        io_valid_i    = 1'b0;
        io_data_ch1_i = 8'h00;
        io_data_ch0_i = 8'h00;
        core_yumi_i   = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] w, input int gap, input bit accept,
                             input bit yumi_last);
        for (int k = 0; k < 4; k++) begin
            if (k == 3 && accept) exp_q.push_back(w);
            beat(w[16*k+15 -: 8], w[16*k+7 -: 8], (k == 3) ? yumi_last : 1'b0);
            if (k < 3) begin
                for (int g = 0; g < gap; g++) begin
                    idle(1);
                    chk("no_early_valid", {63'd0, core_valid_o}, 64'd0);
                end
            end
        end
    endtask

    task automatic pop_n(input int n);
        core_yumi_i = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        core_yumi_i = 1'b0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_token",    {63'd0, io_token_o},   64'd0);
        chk("rst_valid",    {63'd0, core_valid_o}, 64'd0);
        chk("rst_overflow", {63'd0, overflow_o},   64'd0);
        chk("rst_recv",     {57'd0, recv_cnt_o},   64'd0);
        chk("rst_deq",      {57'd0, deq_cnt_o},    64'd0);
        chk("rst_data",     core_data_o,           64'd0);
    endtask

    task automatic do_reset();
        io_valid_i  = 1'b0;
        core_yumi_i = 1'b0;
        rst_n       = 1'b0;
        #2;
        chk_reset_vals();
        exp_q.delete();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] occ;
        rst_n         = 1'b0;
        io_valid_i    = 1'b0;
        io_data_ch0_i = 8'h00;
        io_data_ch1_i = 8'h00;
        core_yumi_i   = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Single contiguous word.
        send_word(64'h8877665544332211, 0, 1'b1, 1'b0);
        chk("single_valid", {63'd0, core_valid_o}, 64'd1);
        chk("single_data",  core_data_o, 64'h8877665544332211);
        chk("single_recv",  {57'd0, recv_cnt_o}, 64'd1);
        pop_n(1);
        chk("single_empty", {63'd0, core_valid_o}, 64'd0);
        chk("single_deq",   {57'd0, deq_cnt_o}, 64'd1);

        // Same word with 3 idle cycles between beats.
        send_word(64'h8877665544332211, 3, 1'b1, 1'b0);
        chk("gap_valid", {63'd0, core_valid_o}, 64'd1);
        chk("gap_recv",  {57'd0, recv_cnt_o}, 64'd2);
        pop_n(1);

        // Token batching over 16 pops.
        do_reset();
        for (int i = 0; i < 8; i++) send_word(wv(i), 0, 1'b1, 1'b0);
        core_yumi_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            chk("token_batch1", {63'd0, io_token_o}, (i == 8) ? 64'd1 : 64'd0);
        end
        core_yumi_i = 1'b0;
        for (int i = 8; i < 16; i++) send_word(wv(i), 0, 1'b1, 1'b0);
        core_yumi_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            chk("token_batch2", {63'd0, io_token_o}, (i == 8) ? 64'd0 : 64'd1);
        end
        core_yumi_i = 1'b0;
        chk("token_deq", {57'd0, deq_cnt_o}, 64'd16);

        // Fill, then overflow on the 17th word.
        do_reset();
        for (int i = 0; i < 16; i++) send_word(wv(i), 0, 1'b1, 1'b0);
        chk("full_valid",    {63'd0, core_valid_o}, 64'd1);
        chk("full_no_ovf",   {63'd0, overflow_o},   64'd0);
        send_word(wv(16), 0, 1'b0, 1'b0);
        chk("ovf_set",       {63'd0, overflow_o},   64'd1);
        chk("ovf_recv",      {57'd0, recv_cnt_o},   64'd16);
        chk("ovf_head",      core_data_o,           wv(0));
        pop_n(16);
        chk("ovf_drained",   {63'd0, core_valid_o}, 64'd0);
        chk("ovf_sticky",    {63'd0, overflow_o},   64'd1);

        // Full with a same-cycle pop: the 17th word is accepted.
        do_reset();
        for (int i = 0; i < 16; i++) send_word(wv(i + 32), 0, 1'b1, 1'b0);
        send_word(wv(48), 0, 1'b1, 1'b1);
        chk("bnd_no_ovf", {63'd0, overflow_o}, 64'd0);
        chk("bnd_recv",   {57'd0, recv_cnt_o}, 64'd17);
        chk("bnd_deq",    {57'd0, deq_cnt_o},  64'd1);
        occ = recv_cnt_o - deq_cnt_o;
        chk("bnd_occ",    {57'd0, occ},        64'd16);
        pop_n(16);
        chk("bnd_drained", {63'd0, core_valid_o}, 64'd0);

        // Reset with three words queued and half a word assembled.
        do_reset();
        for (int i = 0; i < 3; i++) send_word(wv(i + 64), 0, 1'b1, 1'b0);
        beat(8'hAA, 8'hBB, 1'b0);
        beat(8'hCC, 8'hDD, 1'b0);
        do_reset();
        send_word(64'h8877665544332211, 0, 1'b1, 1'b0);
        chk("post_rst_recv", {57'd0, recv_cnt_o}, 64'd1);
        chk("post_rst_data", core_data_o, 64'h8877665544332211);
        pop_n(1);
        idle(2);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
